mixcolumn_seq: RTL and testbench

Sequential, parametrised MixColumns engine for the AES-256-CTR datapath. Accepts one 128-bit state per valid/ready handshake and processes it COLS_PER_CYCLE columns per clock, in forward (encrypt) or inverse (decrypt) mode. It replaces the purely combinational MixColumns stage wherever round logic is time-multiplexed to trade throughput for area. The result is held in a registered output buffer until the consumer accepts it.

---
 rtl/mixcolumn_seq.sv | 148 ++++++++++++++
 tb/tb_mixcolumn_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mixcolumn_seq.sv
// Sequential AES MixColumns engine: one 128-bit state per handshake, COLS_PER_CYCLE columns/clock.
// Define MIXCOLUMN_INV_EN to compile in the InvMixColumns datapath selected by inv_i.
module mixcolumn_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         inv_i,
    input  logic [127:0] mixcolumn_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] mixcolumn_o
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;
    logic [2:0]   col_sum;

`ifdef MIXCOLUMN_INV_EN
    logic         mode_q, mode_d;
`else
    logic         unused_inv;
    assign unused_inv = inv_i;
`endif

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_mix(logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

`ifdef MIXCOLUMN_INV_EN
    function automatic logic [31:0] inv_mix(logic [31:0] c);
        logic [7:0] a[4], x2[4], x4[4], x8[4];
        logic [7:0] m0e[4], m0b[4], m0d[4], m09[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]   = c[31-8*i -: 8];
            x2[i]  = xtime(a[i]);
            x4[i]  = xtime(x2[i]);
            x8[i]  = xtime(x4[i]);
            m0e[i] = x8[i] ^ x4[i] ^ x2[i];
            m0b[i] = x8[i] ^ x2[i] ^ a[i];
            m0d[i] = x8[i] ^ x4[i] ^ a[i];
            m09[i] = x8[i] ^ a[i];
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];
        end
        return r;
    endfunction
`endif

    assign col_sum = {1'b0, col_q} + 3'(COLS_PER_CYCLE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        out_d   = out_q;
`ifdef MIXCOLUMN_INV_EN
        mode_d  = mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    work_d  = mixcolumn_i;
                    col_d   = 2'd0;
                    state_d = StBusy;
`ifdef MIXCOLUMN_INV_EN
                    mode_d  = inv_i;
`endif
                end
            end
            StBusy: begin
                for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
`ifdef MIXCOLUMN_INV_EN
                    work_d[127-32*(int'(col_q)+k) -: 32] = mode_q ?
                        inv_mix(work_q[127-32*(int'(col_q)+k) -: 32]) :
                        fwd_mix(work_q[127-32*(int'(col_q)+k) -: 32]);
`else
                    work_d[127-32*(int'(col_q)+k) -: 32] =
                        fwd_mix(work_q[127-32*(int'(col_q)+k) -: 32]);
`endif
                end
                col_d = col_sum[1:0];
                if (col_sum == 3'd4) begin
                    // Publish the fully transformed state including this cycle's columns
                    out_d   = work_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
`ifdef MIXCOLUMN_INV_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            out_q   <= out_d;
`ifdef MIXCOLUMN_INV_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign out_valid_o = (state_q == StDone);
    assign mixcolumn_o = out_q;

endmodule

// File: tb/tb_mixcolumn_seq.sv
// Bench for mixcolumn_seq: three instances (1, 2 and 4 columns/clock) driven in lockstep.
// Expected results come from directed vectors and an independent shift-and-add GF(2^8) model.
module tb_mixcolumn_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         inv;
    logic         out_ready;
    logic [127:0] din;
    logic [2:0]   rdy, vld;
    logic [127:0] dout[3];

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    int acc[3] = '{0, 0, 0};
    int del[3] = '{0, 0, 0};
    int lat_req[3] = '{4, 2, 1};

    always #5 clk = ~clk;

    mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .inv_i(inv),
        .mixcolumn_i(din), .out_valid_o(vld[0]), .out_ready_i(out_ready), .mixcolumn_o(dout[0])
    );
    mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .inv_i(inv),
        .mixcolumn_i(din), .out_valid_o(vld[1]), .out_ready_i(out_ready), .mixcolumn_o(dout[1])
    );
    mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy[2]), .inv_i(inv),
        .mixcolumn_i(din), .out_valid_o(vld[2]), .out_ready_i(out_ready), .mixcolumn_o(dout[2])
    );

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid && rdy[i]) acc[i] <= acc[i] + 1;
                if (vld[i] && out_ready) del[i] <= del[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(logic [127:0] s, logic iv);
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   acc_b;
        logic [127:0] r;
        if (iv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc_b = 8'h00;
                for (int k = 0; k < 4; k++) acc_b = acc_b ^ gmul(m[(k-row+4)%4], a[k]);
                r[127-32*c-8*row -: 8] = acc_b;
            end
        end
        return r;
    endfunction

    function automatic logic eff_inv(logic iv);
`ifdef MIXCOLUMN_INV_EN
        return iv;
`else
        return 1'b0 & iv;
`endif
    endfunction

    // One lockstep transaction; hold > 0 keeps out_ready low with in_valid pulses for that long.
    task automatic do_txn(input logic [127:0] d, input logic iv, input logic [127:0] exp,
                          input int hold, input string tag);
        int lat[3];
        int cyc;
        lat = '{0, 0, 0};
        in_valid = 1'b1;
        din      = d;
        inv      = iv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = {$urandom, $urandom, $urandom, $urandom};
        inv      = ~iv;
        cyc = 0;
        while (vld != 3'b111 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 3; i++) if (vld[i] && lat[i] == 0) lat[i] = cyc;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 128'(lat[i]), 128'(lat_req[i]));
            check($sformatf("%s_out%0d", tag, i), dout[i], exp);
        end
        check({tag, "_rdy_lo"}, 128'(rdy), 128'(0));
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            din      = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check({tag, "_bp_rdy"}, 128'(rdy), 128'(0));
            check({tag, "_bp_vld"}, 128'(vld), 128'(3'b111));
            for (int i = 0; i < 3; i++) check({tag, "_bp_out"}, dout[i], exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_done++;
        check({tag, "_idle_rdy"}, 128'(rdy), 128'(3'b111));
        check({tag, "_idle_vld"}, 128'(vld), 128'(0));
    endtask

    initial begin
        logic [127:0] d, e;
        logic         iv;
        logic [127:0] inv_exp;
        rst = 1'b1; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 128'(rdy), 128'(0));
        check("rst_vld", 128'(vld), 128'(0));
        for (int i = 0; i < 3; i++) check("rst_out", dout[i], 128'(0));
        rst = 1'b0;
        #1;
        check("rel_rdy", 128'(rdy), 128'(3'b111));

        do_txn(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
               128'h046681e5e0cb199a48f8d37a2806264c, 0, "fwd");
`ifdef MIXCOLUMN_INV_EN
        inv_exp = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
        inv_exp = ref_mix(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
`endif
        do_txn(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, inv_exp, 0, "inv");
        do_txn(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
               128'h8e4da1bc9fdc589d01010101c6c6c6c6, 10, "ident_bp");
        do_txn(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
               128'h046681e5e0cb199a48f8d37a2806264c, 0, "after_bp");

        // Reset two cycles after accept: CPC=1 instance must never present a result
        in_valid = 1'b1; din = 128'hd4bf5d30e0b452aeb84111f11e2798e5; inv = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_vld_a", 128'(vld[0]), 128'(0));
        @(posedge clk); #1;
        check("mid_vld_b", 128'(vld[0]), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_vld", 128'(vld), 128'(0));
        check("mid_rst_rdy", 128'(rdy), 128'(0));
        for (int i = 0; i < 3; i++) check("mid_rst_out", dout[i], 128'(0));
        rst = 1'b0;
        #1;
        check("mid_rel_rdy", 128'(rdy), 128'(3'b111));
        do_txn(128'hd4d4d4d5000000000000000000000000, 1'b0,
               128'hd5d5d7d6000000000000000000000000, 0, "after_rst");

        for (int t = 0; t < 20; t++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(1));
            e  = ref_mix(d, eff_inv(iv));
            do_txn(d, iv, e, int'($urandom_range(3)), $sformatf("rnd%0d", t));
        end

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("acc_cnt%0d", i), 128'(acc[i]), 128'(n_done + 1));
            check($sformatf("del_cnt%0d", i), 128'(del[i]), 128'(n_done));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
